// File: rtl/cp0_timer_intc_pkg.sv
// Shared CP0 address map, register field positions and vector offsets
// for the timer / interrupt-controller slice.
package cp0_timer_intc_pkg;

    // CP0 addresses are {rd[4:0], sel[2:0]}
    localparam logic [7:0] CP0_COUNT      = {5'd9, 3'd0};
    localparam logic [4:0] CP0_COMPARE_RD = 5'd11;
    localparam logic [7:0] CP0_CAUSE      = {5'd13, 3'd0};
    localparam logic [7:0] CP0_INTCTL     = {5'd12, 3'd1};

    function automatic logic [7:0] CP0_COMPARE(input logic [2:0] sel);
        return {CP0_COMPARE_RD, sel};
    endfunction

    // Cause fields: IP occupies 15:8, hardware lines start at bit 10
    localparam int CAUSE_IP_LSB    = 8;
    localparam int CAUSE_IP_HW_LSB = 10;
    localparam int CAUSE_TI        = 30;

    // IntCtl fields
    localparam int INTCTL_VS_LSB   = 5;
    localparam int INTCTL_VS_W     = 5;
    localparam int INTCTL_EDGE_LSB = 16;

    // Exception vector offsets
    localparam logic [11:0] VEC_GENERAL = 12'h180;
    localparam logic [11:0] VEC_INT     = 12'h200;

    // Compare registers come out of reset at all-ones so no match is pending
    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/cp0_compare_ch.sv
// One Compare channel: holds the compare value and its sticky pending bit.
module cp0_compare_ch
    import cp0_timer_intc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] count,
    input  logic        wr,
    input  logic [31:0] wr_data,
    output logic [31:0] compare,
    output logic        tpend
);

    // A write reloads the compare value and acknowledges the interrupt;
    // it wins over a match seen in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            compare <= COMPARE_RST;
            tpend   <= 1'b0;
        end else if (wr) begin
            compare <= wr_data;
            tpend   <= 1'b0;
        end else if (count == compare) begin
            tpend   <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_timer_intc.sv
// CP0 timer and interrupt controller: Count, Compare channels, per-line
// level/edge interrupt capture, Cause.IP/TI and vectored interrupt offset.
module cp0_timer_intc
    import cp0_timer_intc_pkg::*;
#(
    parameter int HW_INTS   = 6,
    parameter int TIMER_CH  = 1,
    parameter int COUNT_DIV = 2,
    parameter int TIMER_IRQ = 5
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [HW_INTS-1:0] hw_int,
    input  logic               mtc0,
    input  logic [31:0]        mtc0_data,
    input  logic [7:0]         addr,
    output logic [31:0]        mfc0_data,
    input  logic [HW_INTS+1:0] status_im,
    input  logic               status_ie,
    input  logic               status_exl,
    input  logic               status_erl,
    input  logic               cause_iv,
    output logic [HW_INTS+1:0] cause_ip,
    output logic               cause_ti,
    output logic               int_sig,
    output logic [11:0]        int_vec_off
);

    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [31:0]         count;
    logic [DIV_W-1:0]    div;
    logic [31:0]         compare [TIMER_CH];
    logic [TIMER_CH-1:0] tpend;
    logic [TIMER_CH-1:0] wr_compare;
    logic                wr_count;
    logic                wr_cause;
    logic                wr_intctl;

    logic [HW_INTS-1:0]  hw_q;
    logic [HW_INTS-1:0]  eff;
    logic [HW_INTS-1:0]  eff_prev;
    logic [HW_INTS-1:0]  rise;
    logic [HW_INTS-1:0]  edge_mode;
    logic [HW_INTS-1:0]  edge_latch;
    logic [HW_INTS-1:0]  ip_hw;
    logic [HW_INTS-1:0]  new_mode;
    logic [HW_INTS-1:0]  clr_mask;
    logic [4:0]          vs;
    logic [1:0]          ip1_0;

    logic [HW_INTS+1:0]  pend;
    logic [3:0]          prio;
    logic [11:0]         vec_step;
    logic [11:0]         vec_add;

    assign wr_count  = mtc0 && (addr == CP0_COUNT);
    assign wr_cause  = mtc0 && (addr == CP0_CAUSE);
    assign wr_intctl = mtc0 && (addr == CP0_INTCTL);
    assign new_mode  = mtc0_data[INTCTL_EDGE_LSB +: HW_INTS];
    assign clr_mask  = mtc0_data[CAUSE_IP_HW_LSB +: HW_INTS];

    // Decode which Compare channel, if any, is being written
    always_comb begin
        wr_compare = '0;
        for (int k = 0; k < TIMER_CH; k++) begin
            wr_compare[k] = mtc0 && (addr == CP0_COMPARE(3'(k)));
        end
    end

    // Count advances once per COUNT_DIV clocks; a software write restarts the prescaler
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            div   <= '0;
        end else if (wr_count) begin
            count <= mtc0_data;
            div   <= '0;
        end else if (div == DIV_LAST) begin
            count <= count + 32'd1;
            div   <= '0;
        end else begin
            div   <= div + 1'b1;
        end
    end

    for (genvar k = 0; k < TIMER_CH; k++) begin : g_ch
        cp0_compare_ch u_ch (
            .clk     (clk),
            .reset   (reset),
            .count   (count),
            .wr      (wr_compare[k]),
            .wr_data (mtc0_data),
            .compare (compare[k]),
            .tpend   (tpend[k])
        );
    end

    assign cause_ti = |tpend;

    // Effective line inputs: registered hw lines with the timer folded into one line
    always_comb begin
        for (int j = 0; j < HW_INTS; j++) begin
            eff[j] = hw_q[j] | (cause_ti && (j == TIMER_IRQ));
        end
    end

    assign rise = eff & ~eff_prev;

    // Line capture state, IntCtl and software IP bits
    always_ff @(posedge clk) begin
        if (reset) begin
            hw_q       <= '0;
            eff_prev   <= '0;
            edge_mode  <= '0;
            edge_latch <= '0;
            vs         <= '0;
            ip1_0      <= '0;
        end else begin
            hw_q     <= hw_int;
            eff_prev <= eff;
            // Switching to level clears; a fresh edge beats a software clear
            for (int j = 0; j < HW_INTS; j++) begin
                if (wr_intctl && !new_mode[j])
                    edge_latch[j] <= 1'b0;
                else if (edge_mode[j] && rise[j])
                    edge_latch[j] <= 1'b1;
                else if (wr_cause && clr_mask[j])
                    edge_latch[j] <= 1'b0;
            end
            if (wr_intctl) begin
                edge_mode <= new_mode;
                vs        <= mtc0_data[INTCTL_VS_LSB +: INTCTL_VS_W];
            end
            if (wr_cause) begin
                ip1_0 <= mtc0_data[CAUSE_IP_LSB +: 2];
            end
        end
    end

    assign ip_hw    = (edge_mode & edge_latch) | (~edge_mode & eff);
    assign cause_ip = {ip_hw, ip1_0};

    assign int_sig = (|(cause_ip & status_im)) & status_ie & ~status_exl & ~status_erl;

    // Vector offset: highest pending unmasked line scaled by the vector spacing
    always_comb begin
        pend = cause_ip & status_im;
        prio = '0;
        for (int i = 0; i < HW_INTS + 2; i++) begin
            if (pend[i]) prio = 4'(i);
        end
        vec_step = {2'b00, vs, 5'b00000};
        vec_add  = {8'b0, prio} * vec_step;
        if (!cause_iv)
            int_vec_off = VEC_GENERAL;
        else if (vs == 5'd0)
            int_vec_off = VEC_INT;
        else
            int_vec_off = VEC_INT + vec_add;
    end

    // Read mux; addresses not owned here read as zero
    always_comb begin
        mfc0_data = '0;
        if (addr == CP0_COUNT) begin
            mfc0_data = count;
        end else if (addr[7:3] == CP0_COMPARE_RD) begin
            for (int k = 0; k < TIMER_CH; k++) begin
                if (addr[2:0] == 3'(k)) mfc0_data = compare[k];
            end
        end else if (addr == CP0_CAUSE) begin
            mfc0_data[CAUSE_IP_LSB +: HW_INTS+2] = cause_ip;
            mfc0_data[CAUSE_TI]                  = cause_ti;
        end else if (addr == CP0_INTCTL) begin
            mfc0_data[INTCTL_EDGE_LSB +: HW_INTS]    = edge_mode;
            mfc0_data[INTCTL_VS_LSB +: INTCTL_VS_W]  = vs;
        end
    end

endmodule

// File: tb/tb_cp0_timer_intc.sv
// Bench for cp0_timer_intc: directed scenarios plus random traffic, every
// cycle checked against a behavioural model through an expected queue.
module tb_cp0_timer_intc;

    localparam int HW    = 6;
    localparam int TCH   = 2;
    localparam int DIV   = 2;
    localparam int TIRQ  = 5;
    localparam int OBS_W = 54;

    localparam logic [7:0] A_COUNT  = 8'h48;
    localparam logic [7:0] A_CMP0   = 8'h58;
    localparam logic [7:0] A_CMP1   = 8'h59;
    localparam logic [7:0] A_CMP2   = 8'h5A;
    localparam logic [7:0] A_CMP3   = 8'h5B;
    localparam logic [7:0] A_CAUSE  = 8'h68;
    localparam logic [7:0] A_INTCTL = 8'h61;
    localparam logic [7:0] A_STATUS = 8'h60;

    // clock / reset and DUT signals
    logic          clk;
    logic          reset;
    logic [HW-1:0] hw_int;
    logic          mtc0;
    logic [31:0]   mtc0_data;
    logic [7:0]    addr;
    logic [31:0]   mfc0_data;
    logic [HW+1:0] status_im;
    logic          status_ie, status_exl, status_erl, cause_iv;
    logic [HW+1:0] cause_ip;
    logic          cause_ti, int_sig;
    logic [11:0]   int_vec_off;

    int errors = 0;
    int checks = 0;
    logic [OBS_W-1:0] exp_q[$];

    cp0_timer_intc #(.HW_INTS(HW), .TIMER_CH(TCH), .COUNT_DIV(DIV), .TIMER_IRQ(TIRQ)) dut (
        .clk(clk), .reset(reset), .hw_int(hw_int), .mtc0(mtc0), .mtc0_data(mtc0_data),
        .addr(addr), .mfc0_data(mfc0_data), .status_im(status_im), .status_ie(status_ie),
        .status_exl(status_exl), .status_erl(status_erl), .cause_iv(cause_iv),
        .cause_ip(cause_ip), .cause_ti(cause_ti), .int_sig(int_sig), .int_vec_off(int_vec_off)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic [31:0]   m_base;
    int            m_cyc;
    logic [31:0]   m_cmp [TCH];
    logic [TCH-1:0] m_tp;
    logic [HW-1:0] m_hwq, m_prev, m_mode, m_latch;
    logic [4:0]    m_vs;
    logic [1:0]    m_ip10;

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_cyc / DIV);
    endfunction

    function automatic logic [HW-1:0] m_eff();
        logic [HW-1:0] e;
        e = m_hwq;
        if (|m_tp) e[TIRQ] = 1'b1;
        return e;
    endfunction

    function automatic logic [HW+1:0] m_ip();
        logic [HW-1:0] e;
        e = m_eff();
        return {(m_mode & m_latch) | (~m_mode & e), m_ip10};
    endfunction

    function automatic logic [OBS_W-1:0] exp_obs();
        logic [31:0]   rd;
        logic [HW+1:0] ip;
        logic          irq;
        logic [11:0]   vec;
        int            p;
        ip = m_ip();
        rd = 32'd0;
        case (addr)
            A_COUNT:  rd = m_count();
            A_CMP0:   rd = m_cmp[0];
            A_CMP1:   rd = m_cmp[1];
            A_CAUSE:  rd = {1'b0, |m_tp, 14'd0, ip, 8'd0};
            A_INTCTL: rd = (32'(m_mode) << 16) | (32'(m_vs) << 5);
            default:  rd = 32'd0;
        endcase
        irq = (|(ip & status_im)) && status_ie && !status_exl && !status_erl;
        p = 0;
        for (int i = 0; i < HW + 2; i++) if (ip[i] && status_im[i]) p = i;
        if (!cause_iv) vec = 12'h180;
        else vec = 12'((32'h200 + p * int'(m_vs) * 32) & 32'hFFF);
        return {rd, ip, |m_tp, irq, vec};
    endfunction

    task automatic model_clock();
        logic [31:0]   c;
        logic [HW-1:0] e, r, nl;
        if (reset) begin
            m_base = 0; m_cyc = 0; m_tp = 0;
            for (int k = 0; k < TCH; k++) m_cmp[k] = 32'hFFFF_FFFF;
            m_hwq = 0; m_prev = 0; m_mode = 0; m_latch = 0; m_vs = 0; m_ip10 = 0;
        end else begin
            c = m_count();
            e = m_eff();
            r = e & ~m_prev;
            for (int k = 0; k < TCH; k++) begin
                if (mtc0 && addr == {5'd11, 3'(k)}) begin
                    m_cmp[k] = mtc0_data;
                    m_tp[k]  = 1'b0;
                end else if (c == m_cmp[k]) begin
                    m_tp[k] = 1'b1;
                end
            end
            if (mtc0 && addr == A_COUNT) begin
                m_base = mtc0_data;
                m_cyc  = 0;
            end else begin
                m_cyc++;
            end
            nl = m_latch;
            if (mtc0 && addr == A_CAUSE) begin
                nl     = nl & ~mtc0_data[15:10];
                m_ip10 = mtc0_data[9:8];
            end
            nl = nl | (m_mode & r);
            if (mtc0 && addr == A_INTCTL) begin
                nl     = nl & mtc0_data[21:16];
                m_mode = mtc0_data[21:16];
                m_vs   = mtc0_data[9:5];
            end
            m_latch = nl;
            m_prev  = e;
            m_hwq   = hw_int;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        exp_q.push_back(exp_obs());
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [7:0] keep;
        keep = addr;
        mtc0 = 1'b1; addr = a; mtc0_data = d;
        step();
        mtc0 = 1'b0; addr = keep;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [OBS_W-1:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("mfc0_data",   mfc0_data,          mon_e[53:22]);
            chk("cause_ip",    32'(cause_ip),      32'(mon_e[21:14]));
            chk("cause_ti",    32'(cause_ti),      32'(mon_e[13]));
            chk("int_sig",     32'(int_sig),       32'(mon_e[12]));
            chk("int_vec_off", 32'(int_vec_off),   32'(mon_e[11:0]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  pool [8];
        logic [7:0]  a;
        logic [31:0] d;
        pool[0] = A_COUNT;  pool[1] = A_CMP0; pool[2] = A_CMP1;   pool[3] = A_CMP3;
        pool[4] = A_CAUSE;  pool[5] = A_INTCTL; pool[6] = A_STATUS; pool[7] = A_CMP2;

        reset = 1'b1; hw_int = '0; mtc0 = 1'b0; mtc0_data = '0; addr = A_COUNT;
        status_im = '0; status_ie = 1'b0; status_exl = 1'b0; status_erl = 1'b0; cause_iv = 1'b0;
        for (int k = 0; k < TCH; k++) m_cmp[k] = 32'hFFFF_FFFF;
        m_base = 0; m_cyc = 0; m_tp = 0; m_hwq = 0; m_prev = 0; m_mode = 0; m_latch = 0; m_vs = 0; m_ip10 = 0;

        // reset, then free-running count
        @(posedge clk); #1;
        run(2);
        reset = 1'b0;
        run(11);
        // wrap and write-vs-increment priority at each prescaler phase
        wr(A_COUNT, 32'hFFFF_FFFF);
        run(3);
        for (int i = 0; i < 4; i++) begin
            run(i);
            wr(A_COUNT, 32'h1234_0000 + 32'(i));
            run(2);
        end
        wr(A_CMP0, 32'hFFFF_FFFF);

        // timer match on channel 1 routed into IP7
        status_im = 8'hFF; status_ie = 1'b1;
        addr = A_CAUSE;
        wr(A_COUNT, 32'd10);
        wr(A_CMP1, 32'd20);
        run(26);
        wr(A_CMP1, 32'd1000);
        run(3);

        // line 0 level pulse, then edge mode with clear
        hw_int[0] = 1'b1; step(); hw_int[0] = 1'b0; run(4);
        wr(A_INTCTL, 32'h0001_0000);
        run(2);
        hw_int[0] = 1'b1; step(); hw_int[0] = 1'b0; run(5);
        wr(A_CAUSE, 32'h0000_0400);
        run(2);
        hw_int[0] = 1'b1; step(); hw_int[0] = 1'b0; run(3);
        hw_int[0] = 1'b1; step(); hw_int[0] = 1'b0;
        wr(A_CAUSE, 32'h0000_0400);
        run(3);
        wr(A_CAUSE, 32'h0000_0400);
        run(2);
        hw_int[0] = 1'b1; step(); hw_int[0] = 1'b0; run(2);
        wr(A_INTCTL, 32'h0);
        run(2);

        // vectored offsets
        wr(A_INTCTL, 32'h0000_0020);
        hw_int = 6'b010100; cause_iv = 1'b1; status_im = 8'hFF;
        run(3);
        status_im = 8'hBF; run(2);
        cause_iv = 1'b0; run(2);
        hw_int = '0; run(2);

        // EXL / ERL masking, software IP0
        status_im = 8'hFF; hw_int = 6'b000001;
        status_exl = 1'b1; run(2);
        status_exl = 1'b0; status_erl = 1'b1; run(2);
        status_erl = 1'b0; hw_int = '0; status_im = 8'h01;
        wr(A_CAUSE, 32'h0000_0100);
        run(2);
        wr(A_CAUSE, 32'h0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) hw_int = hw_int ^ (6'b1 << $urandom_range(0, HW - 1));
            if ($urandom_range(0, 15) == 0) begin
                status_im  = 8'($urandom);
                status_ie  = 1'($urandom);
                status_exl = ($urandom_range(0, 3) == 0);
                status_erl = ($urandom_range(0, 5) == 0);
                cause_iv   = 1'($urandom);
            end
            addr  = pool[$urandom_range(0, 7)];
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 5) == 0) begin
                a = pool[$urandom_range(0, 7)];
                d = $urandom;
                if (a == A_COUNT && $urandom_range(0, 1) == 1)
                    d = m_cmp[$urandom_range(0, TCH - 1)] - 32'($urandom_range(0, 8));
                else if ((a == A_CMP0 || a == A_CMP1) && $urandom_range(0, 1) == 1)
                    d = m_count() + 32'($urandom_range(0, 8));
                mtc0 = 1'b1; addr = a; mtc0_data = d;
            end
            step();
            mtc0 = 1'b0;
            reset = 1'b0;
        end

        // mid-operation reset with timer pending and edge latches full
        status_im = 8'hFF; status_ie = 1'b1; status_exl = 1'b0; status_erl = 1'b0; cause_iv = 1'b0;
        hw_int = '0;
        addr = A_CAUSE;
        wr(A_INTCTL, 32'h003F_0000);
        wr(A_CMP0, m_count() + 32'd1);
        run(4);
        hw_int = 6'h3F; step(); hw_int = '0; run(3);
        reset = 1'b1; step();
        reset = 1'b0; run(2);
        addr = A_CMP3; run(1);
        addr = A_CMP2; run(1);
        addr = A_COUNT; run(2);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_timer_intc.md
Name: cp0_timer_intc

Overview:
- Parametrised timer and interrupt-controller slice for the CP0 register file, successor to the single Count/Compare + fixed 6-line IP logic.
- Owns Count, TIMER_CH Compare channels, the per-line level/edge interrupt mode, the Cause.IP/TI fields and the vectored-interrupt offset.
- The CP0 file forwards mtc0/mfc0 traffic for these addresses and ORs mfc0_data into its read mux.
- Consumes Status.IM/IE/EXL/ERL and drives int_sig to the commit stage.

Parameters:
- HW_INTS, 6: hardware interrupt lines (IP[HW_INTS+1:2]); range 1..6.
- TIMER_CH, 1: Compare channels (sel 0..TIMER_CH-1 at reg 11); range 1..4.
- COUNT_DIV, 2: Count increments once every COUNT_DIV clocks; range ≥1.
- TIMER_IRQ, 5: hardware line index (0-based) that the timer interrupt is ORed into.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- hw_int  in  HW_INTS  raw external interrupt lines, already synchronous to clk
- mtc0  in  1  CP0 write strobe
- mtc0_data  in  32  write data
- addr  in  8  {rd[4:0], sel[2:0]}
- mfc0_data  out  32  read data; 0 for addresses not owned here
- status_im  in  HW_INTS+2  Status.IM
- status_ie, status_exl, status_erl  in  1 each  Status bits
- cause_iv  in  1  Cause.IV
- cause_ip  out  HW_INTS+2  {IP hw lines, IP1_0}
- cause_ti  out  1  OR of timer pending bits
- int_sig  out  1  unmasked interrupt request
- int_vec_off  out  12  exception vector offset for an interrupt

Behaviour:
- Reset values: count=0, div=0, compare[k]=32'hFFFF_FFFF, tpend=0, ip1_0=0, edge_mode=0 (all level), edge_latch=0, hw_q=0, vs=0. All outputs are therefore 0, except int_vec_off=12'h180.
- Count (9,0):
  - div counts 0..COUNT_DIV-1. count++ on the cycle div==COUNT_DIV-1, then div returns to 0.
  - mtc0 Count: count<=data, div<=0. The write takes priority over the increment.
  - Wraps 32'hFFFF_FFFF -> 0 silently.
- Compare k (11,k):
  - mtc0 Compare k: compare[k]<=data and tpend[k]<=0. The write wins over a match in the same cycle.
  - Otherwise tpend[k] is set in the cycle after count==compare[k] holds. It is sticky until Compare k is written.
  - sel ≥ TIMER_CH: writes are ignored, reads return 0.
- cause_ti = |tpend (combinational from flops).
- Hardware lines:
  - hw_q <= hw_int each cycle. Line j's effective input is hw_q[j], ORed with cause_ti when j==TIMER_IRQ.
  - Level mode: IP[j+2] = effective input.
  - Edge mode: a rising edge of the effective input (cur & ~prev) sets edge_latch[j], and IP[j+2] = edge_latch[j]. The edge is detected on the registered value, so IP rises 2 cycles after a hw_int edge.
  - mtc0 Cause with data bit (j+10)=1 clears edge_latch[j]. A clear and a set in the same cycle leaves the latch set.
  - Level-mode lines are unaffected by Cause writes.
- IP1_0: mtc0 Cause writes data[9:8]; read back in cause_ip[1:0].
- IntCtl (12,1):
  - Read value: {bits[31:16+HW_INTS]=0, edge_mode[HW_INTS-1:0] at 16+, 6'b0, vs[4:0] at 9:5, 5'b0}.
  - mtc0 writes edge_mode and vs.
  - Changing a line to level mode clears its edge_latch.
- int_sig = |(cause_ip & status_im) & status_ie & ~status_exl & ~status_erl (combinational).
- int_vec_off:
  - If !cause_iv: 12'h180.
  - Else if vs==0: 12'h200.
  - Else: 12'h200 + p*(vs<<5), where p = highest index with cause_ip[p]&status_im[p] set (0 if none). Arithmetic is 12-bit, truncating.
- Read mux: Count, Compare k, Cause fields (bits 15:8 = cause_ip zero-extended, bit 30 = cause_ti; all other Cause bits 0, since the CP0 file ORs in BD/ExcCode/IV), IntCtl.
- Reset mid-operation clears all state in one cycle. There is no pending-interrupt carry-over.

Decomposition:
- Shared package/header:
  - CP0 address constants CP0_COUNT, CP0_COMPARE(sel), CP0_CAUSE, CP0_INTCTL.
  - Field ranges CAUSE_IP, CAUSE_TI, INTCTL_VS, INTCTL_EDGE.
  - Vector offsets VEC_GENERAL=12'h180, VEC_INT=12'h200.
- Sub-module cp0_compare_ch, instantiated TIMER_CH times: holds compare[k] and tpend[k], with inputs count, write strobe and data.

Test Plan:
- COUNT_DIV=2, reset, run 10 clk -> count reads 5. Write Count=32'hFFFF_FFFF, run 2 clk -> count 0. Write Count during an increment cycle -> written value wins.
- TIMER_CH=2: Compare1=20, Compare0=FFFF_FFFF, IM7=1, IE=1 -> cause_ti and cause_ip[7] rise the cycle after count==20, and int_sig=1. Write Compare1 -> cause_ti 0 next cycle.
- Line 0 level mode, pulse hw_int[0] for 1 cycle -> cause_ip[2] high for exactly 1 cycle, 1 cycle late. Same pulse in edge mode -> cause_ip[2] stays 1 until mtc0 Cause with bit 10 set; a pulse in the clear cycle keeps it 1.
- cause_iv=1, vs=1, IP4 and IP6 pending, IM=8'hFF -> int_vec_off = 12'h200+6*32 = 12'h2C0. Mask IM6 -> 12'h280. cause_iv=0 -> 12'h180.
- IE=1, EXL=1 with IP pending -> int_sig=0. ERL=1 -> int_sig=0. Write IP1_0=2'b01 with IM0=1, EXL=0, ERL=0 -> int_sig=1.
- Assert reset with tpend set and edge latches full -> the next cycle all outputs are 0 and int_vec_off=12'h180. Read Compare sel 3 with TIMER_CH=2 -> 0.
